// File: rtl/jk_bank_sequencer.sv
// -----------------------------------------------------------------------------
// jk_bank_sequencer
//
// Drives the J/K inputs of an external bank of WIDTH JK flip-flops so that the
// bank is loaded, cleared, or counted up/down by a number of steps. One
// command is taken at a time through a valid/ready handshake. Each bank update
// is an APPLY cycle, which is followed by a SETTLE cycle. A DONE cycle
// finishes the command.
//
// Ports
//   clock      : sole clock, rising edge
//   resetnot   : asynchronous active-low reset
//   cmd_valid  : command offered
//   cmd_ready  : high only in IDLE; a command is taken when valid & ready
//   cmd_op     : 00 LOAD, 01 COUNT_UP, 10 COUNT_DOWN, 11 CLEAR
//   cmd_data   : LOAD value or step count (unused for CLEAR)
//   Q_bank     : present Q outputs of the flip-flop bank
//   J, K       : flip-flop bank inputs; all zero outside APPLY
//   apply      : one-cycle strobe; the bank updates from J/K while high
//   busy       : high in every state except IDLE
//   done       : one-cycle completion pulse
// -----------------------------------------------------------------------------
module jk_bank_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             resetnot,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] Q_bank,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             apply,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_steps;
    logic [WIDTH-1:0] w_steps_nxt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic             w_accept;
    logic [WIDTH-1:0] w_t_up;
    logic [WIDTH-1:0] w_t_dn;

    assign w_accept = cmd_valid && (r_state == S_IDLE);

    // State and step counter. These are the only registers that need reset.
    always_ff @(posedge clock or negedge resetnot) begin
        if (!resetnot) begin
            r_state <= S_IDLE;
            r_steps <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_steps <= w_steps_nxt;
        end
    end

    // The command is captured at acceptance, so later changes on cmd_op/cmd_data
    // do not affect it. This is data only; the FSM never reads it outside
    // APPLY, which is why it needs no reset.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_op   <= cmd_op;
            r_data <= cmd_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_steps_nxt = r_steps;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == OP_LOAD || cmd_op == OP_CLEAR) begin
                        w_state_nxt = S_APPLY;
                        w_steps_nxt = WIDTH'(1);
                    end else if (cmd_data != '0) begin
                        w_state_nxt = S_APPLY;
                        w_steps_nxt = cmd_data;
                    end else begin
                        // A count of zero steps completes without touching the bank.
                        w_state_nxt = S_DONE;
                        w_steps_nxt = '0;
                    end
                end
            end
            S_APPLY: begin
                w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_steps > WIDTH'(1)) begin
                    w_steps_nxt = r_steps - WIDTH'(1);
                    w_state_nxt = S_APPLY;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Ripple toggle masks for a synchronous binary counter. Bit i toggles
    // when all lower bits are 1 (counting up) or all are 0 (counting down).
    always_comb begin
        logic w_run1;
        logic w_run0;
        w_run1 = 1'b1;
        w_run0 = 1'b1;
        w_t_up = '0;
        w_t_dn = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_t_up[i] = w_run1;
            w_t_dn[i] = w_run0;
            w_run1    = w_run1 & Q_bank[i];
            w_run0    = w_run0 & ~Q_bank[i];
        end
    end

    always_comb begin
        J = '0;
        K = '0;
        if (r_state == S_APPLY) begin
            case (r_op)
                OP_LOAD: begin
                    J = r_data;
                    K = ~r_data;
                end
                OP_UP: begin
                    J = w_t_up;
                    K = w_t_up;
                end
                OP_DOWN: begin
                    J = w_t_dn;
                    K = w_t_dn;
                end
                OP_CLEAR: begin
                    J = '0;
                    K = '1;
                end
                default: begin
                    J = '0;
                    K = '0;
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign apply     = (r_state == S_APPLY);
    assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// -----------------------------------------------------------------------------
// tb_jk_bank_sequencer
//
// Self-checking bench for jk_bank_sequencer (WIDTH=4). It models an external
// JK flip-flop bank and runs a table of directed commands. It then runs
// hand-written sequences for the busy-offer case and the mid-command reset
// case. Finally it runs randomized commands against an arithmetic reference
// model.
// -----------------------------------------------------------------------------
module tb_jk_bank_sequencer;

    localparam int W = 4;

    logic         clock      = 1'b0;
    logic         resetnot   = 1'b1;
    logic         cmd_valid  = 1'b0;
    logic [1:0]   cmd_op     = 2'b00;
    logic [W-1:0] cmd_data   = '0;
    logic [W-1:0] q_bank     = '0;
    logic         preset_en  = 1'b0;
    logic [W-1:0] preset_val = '0;
    logic         cmd_ready;
    logic [W-1:0] J;
    logic [W-1:0] K;
    logic         apply;
    logic         busy;
    logic         done;

    int n_total = 0;
    int n_pass  = 0;

    jk_bank_sequencer #(.WIDTH(W)) dut (
        .clock     (clock),
        .resetnot  (resetnot),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .Q_bank    (q_bank),
        .J         (J),
        .K         (K),
        .apply     (apply),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        case ({j, k})
            2'b00:   return q;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~q;
        endcase
    endfunction

    // External flip-flop bank; preset_en lets the bench force a start value.
    always @(posedge clock) begin
        if (preset_en) q_bank <= preset_val;
        else if (apply)
            for (int i = 0; i < W; i++) q_bank[i] <= jk_next(q_bank[i], J[i], K[i]);
    end

    // Reference model: the whole command as plain arithmetic.
    function automatic logic [W-1:0] ref_final(input logic [1:0] op, input logic [W-1:0] d,
                                               input logic [W-1:0] q);
        case (op)
            2'b00:   return d;
            2'b01:   return q + d;
            2'b10:   return q - d;
            default: return '0;
        endcase
    endfunction

    function automatic int ref_steps(input logic [1:0] op, input logic [W-1:0] d);
        if (op == 2'b00 || op == 2'b11) return 1;
        return int'(d);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preset(input logic [W-1:0] v);
        preset_val = v;
        preset_en  = 1'b1;
        tick();
        preset_en  = 1'b0;
    endtask

    // Issue one command and follow it to completion. The bench is called and
    // returns at 1 time unit after a rising edge, with the DUT idle.
    task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] d, input logic [W-1:0] exp_q,
                           input int exp_app, input int exp_done, input bit junk);
        logic [W-1:0] qm;
        logic [W-1:0] ej;
        logic [W-1:0] ek;
        logic [W-1:0] qn;
        int           dcyc;
        bit           exp_ap;
        qm = q_bank;
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
        dcyc      = 0;
        for (int c = 1; c <= 40 && dcyc == 0; c++) begin
            exp_ap = (exp_app > 0) && (c % 2 == 1) && (c < exp_done);
            chk("q_track", q_bank, qm);
            chk("busy_in_cmd", busy, 1);
            chk("ready_in_cmd", cmd_ready, 0);
            chk("apply_slot", apply, exp_ap);
            chk("done_slot", done, (c == exp_done));
            if (exp_ap) begin
                case (op)
                    2'b00:   begin ej = d;                ek = ~d;    qn = d;        end
                    2'b01:   begin ej = qm ^ (qm + 4'd1); ek = ej;    qn = qm + 4'd1; end
                    2'b10:   begin ej = qm ^ (qm - 4'd1); ek = ej;    qn = qm - 4'd1; end
                    default: begin ej = '0;               ek = '1;    qn = '0;       end
                endcase
                chk("J_apply", J, ej);
                chk("K_apply", K, ek);
                qm = qn;
            end else begin
                chk("J_idle_zero", J, 0);
                chk("K_idle_zero", K, 0);
            end
            if (done) dcyc = c;
            if (junk) begin
                cmd_valid = 1'($urandom);
                cmd_op    = 2'($urandom);
                cmd_data  = 4'($urandom);
            end
            tick();
        end
        cmd_valid = 1'b0;
        chk("done_cycle", dcyc, exp_done);
        chk("ready_after", cmd_ready, 1);
        chk("busy_after", busy, 0);
        chk("done_after", done, 0);
        chk("q_final", q_bank, exp_q);
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] data;
        logic [W-1:0] q0;
        logic [W-1:0] exp_q;
        int           exp_app;
        int           exp_done;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int           dc;
        logic [1:0]   rop;
        logic [W-1:0] rd;
        int           st;

        vecs[0] = '{2'b00, 4'b1010, 4'b0000, 4'b1010,  1,  3};
        vecs[1] = '{2'b01, 4'd3,    4'b1110, 4'b0001,  3,  7};
        vecs[2] = '{2'b10, 4'd1,    4'b0000, 4'b1111,  1,  3};
        vecs[3] = '{2'b01, 4'd0,    4'b0101, 4'b0101,  0,  1};
        vecs[4] = '{2'b11, 4'b0110, 4'b1011, 4'b0000,  1,  3};
        vecs[5] = '{2'b10, 4'd2,    4'b0001, 4'b1111,  2,  5};
        vecs[6] = '{2'b01, 4'd15,   4'b0000, 4'b1111, 15, 31};
        vecs[7] = '{2'b00, 4'b0000, 4'b1111, 4'b0000,  1,  3};

        // Reset values, before any clock edge and across an edge.
        #1 resetnot = 1'b0;
        #1;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_apply", apply, 0);
        chk("rst_done", done, 0);
        chk("rst_J", J, 0);
        chk("rst_K", K, 0);
        cmd_valid = 1'b1;
        tick();
        chk("rst_hold_busy", busy, 0);
        chk("rst_hold_ready", cmd_ready, 1);
        cmd_valid = 1'b0;
        @(negedge clock);
        resetnot = 1'b1;
        tick();

        // Directed table.
        foreach (vecs[i]) begin
            preset(vecs[i].q0);
            run_cmd(vecs[i].op, vecs[i].data, vecs[i].exp_q,
                    vecs[i].exp_app, vecs[i].exp_done, 1'b0);
        end

        // A command held on the bus during COUNT_UP 5 waits until the idle cycle after done.
        preset(4'b0000);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_data  = 4'd5;
        tick();
        cmd_op    = 2'b00;
        cmd_data  = 4'b0110;
        dc        = 0;
        for (int c = 1; c <= 20 && dc == 0; c++) begin
            chk("offer_ready_busy", cmd_ready, 0);
            if (done) dc = c;
            tick();
        end
        chk("offer_done_cycle", dc, 11);
        chk("offer_ready_idle", cmd_ready, 1);
        chk("offer_q_after_up5", q_bank, 4'd5);
        tick();
        cmd_valid = 1'b0;
        chk("offer_accept_apply", apply, 1);
        chk("offer_accept_J", J, 4'b0110);
        chk("offer_accept_K", K, 4'b1001);
        tick();
        tick();
        chk("offer_load_done", done, 1);
        tick();
        chk("offer_load_q", q_bank, 4'b0110);

        // Reset during the second SETTLE of COUNT_UP 4.
        preset(4'b0000);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_data  = 4'd4;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("abort_pre_busy", busy, 1);
        chk("abort_pre_apply", apply, 0);
        resetnot = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_ready", cmd_ready, 1);
        chk("abort_apply", apply, 0);
        chk("abort_done", done, 0);
        chk("abort_J", J, 0);
        chk("abort_K", K, 0);
        tick();
        chk("abort_hold_busy", busy, 0);
        @(negedge clock);
        resetnot = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("abort_no_done", done, 0);
            chk("abort_no_apply", apply, 0);
            chk("abort_ready_rel", cmd_ready, 1);
        end
        chk("abort_q_kept", q_bank, 4'd2);
        run_cmd(2'b00, 4'b1100, 4'b1100, 1, 3, 1'b0);

        // Randomized commands against the reference model.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) preset(4'($urandom));
            repeat ($urandom_range(0, 2)) tick();
            rop = 2'($urandom);
            rd  = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom);
            st  = ref_steps(rop, rd);
            run_cmd(rop, rd, ref_final(rop, rd, q_bank), st, 2 * st + 1, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/jk_bank_sequencer.md
JK_BANK_SEQUENCER -- requirements
Module: jk_bank_sequencer

Interface
REQ-001 The block SHALL have exactly one parameter:
  - WIDTH, default 4, number of JK flip-flops in the controlled bank.
REQ-002 The block SHALL have the following ports:
  - clock  input  1  sole clock; all state changes on rising edge
  - resetnot  input  1  asynchronous, active-low reset
  - cmd_valid  input  1  command offered
  - cmd_ready  output  1  command accepted when high together with cmd_valid
  - cmd_op  input  2  00 LOAD, 01 COUNT_UP, 10 COUNT_DOWN, 11 CLEAR
  - cmd_data  input  WIDTH  LOAD value, or step count for COUNT_UP/COUNT_DOWN; ignored for CLEAR
  - Q_bank  input  WIDTH  current Q outputs of the flip-flop bank
  - J  output  WIDTH  J inputs to the bank
  - K  output  WIDTH  K inputs to the bank
  - apply  output  1  one-cycle strobe; the bank updates from J/K while high
  - busy  output  1  high in every state except IDLE
  - done  output  1  one-cycle pulse on command completion
REQ-003 The clock is named clock and the reset is named resetnot; reset is asynchronous, active-low, and there is only one clock.

Function
REQ-004 The FSM SHALL have four states: IDLE, APPLY, SETTLE, DONE; all outputs SHALL be registered or decoded from state only.
REQ-005 cmd_ready SHALL be 1 only in IDLE; a command is accepted on the rising edge where cmd_valid=1 and cmd_ready=1, latching cmd_op and cmd_data.
REQ-006 On acceptance: LOAD and CLEAR go to APPLY with step count 1; COUNT with cmd_data≠0 goes to APPLY with step count cmd_data; COUNT with cmd_data=0 goes directly to DONE without any apply.
REQ-007 In APPLY, apply=1 for exactly one cycle, and J/K are computed combinationally from Q_bank in that cycle:
  - LOAD: J=data, K=~data
  - CLEAR: J=0, K=all ones
  - COUNT_UP: J=K=T, where T[i]=1 iff Q_bank[i-1:0] are all 1 (T[0]=1)
  - COUNT_DOWN: J=K=T, where T[i]=1 iff Q_bank[i-1:0] are all 0 (T[0]=1)
REQ-008 J and K SHALL be all zero in every cycle where apply=0.
REQ-009 APPLY SHALL always go to SETTLE; SETTLE lasts one cycle with apply=0.
REQ-010 From SETTLE: if remaining steps > 1, decrement the step count and go to APPLY; otherwise go to DONE.
REQ-011 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-012 Latency for a command accepted at edge T:
  - LOAD/CLEAR: apply in cycle T+1, done in cycle T+3, cmd_ready=1 again in cycle T+4.
  - COUNT with N steps: apply in cycles T+1+2k (k=0..N-1), done in cycle T+1+2N.
REQ-013 Counting SHALL wrap modulo 2^WIDTH: up from all ones yields 0, and down from 0 yields all ones; there is no saturation and no error.
REQ-014 Step count is an unsigned WIDTH-bit value, so the maximum is 2^WIDTH-1 steps per command.
REQ-015 cmd_valid is ignored while busy=1; commands are never queued and never dropped once accepted.
REQ-016 cmd_op/cmd_data changes after acceptance SHALL NOT affect the command in progress.

Reset
REQ-017 While resetnot=0, regardless of clock: state=IDLE, step count=0, J=0, K=0, apply=0, busy=0, done=0, cmd_ready=1.
REQ-018 Reset asserted mid-command SHALL abort the command immediately, with no further apply pulse and no done pulse.
REQ-019 After reset release, the first rising edge with cmd_valid=1 SHALL be accepted.

Verification
REQ-020 The bench SHALL cover at least these directed scenarios (WIDTH=4, bank modelled with the team's JK flip-flop):
  - LOAD 4'b1010 from Q=0: one apply with J=1010, K=0101; Q=1010; done 3 cycles after acceptance.
  - COUNT_UP 3 from Q=1110: Q sequence 1111, 0000, 0001; 3 apply pulses spaced 2 cycles apart; a single done pulse.
  - COUNT_DOWN 1 from Q=0000: J=K=1111; Q=1111.
  - COUNT_UP 0: no apply; done in the cycle after acceptance; Q unchanged.
  - Command offered while busy during a COUNT_UP 5: not accepted; it is accepted in the cycle after done.
  - resetnot pulsed low during the 2nd SETTLE of COUNT_UP 4: outputs go to reset values immediately; no done; cmd_ready=1 after release.
